// File: rtl/adc_packetizer.sv
// ADC byte packetizer: buffers ADC bytes in a FIFO and emits fixed-size packets
// (4-byte header of MAGIC + sequence number, then the payload), separated by idle gaps.
module adc_packetizer #(
  parameter int          PAYLOAD_BYTES = 1024,
  parameter int          FIFO_DEPTH    = 4096,
  parameter int          GAP_CYCLES    = 64,
  parameter logic [15:0] MAGIC         = 16'hADC0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  din,
  input  logic                        din_valid,
  input  logic                        tx_busy,
  output logic [7:0]                  dout,
  output logic                        dout_valid,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fill,
  output logic [1:0]                  state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(PAYLOAD_BYTES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HDR     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_GAP     = 2'd3
  } state_e;

  // Handshake: din has no backpressure, a byte is taken whenever din_valid=1 and
  // the FIFO has room (or is being read the same cycle); dout_valid marks every
  // packet byte and stays high for the whole packet with no ready from the sink.

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   fill_q, fill_d;
  logic          overflow_q;
  logic          full, wr_en, rd_en;

  state_e        state_q;
  logic [1:0]    hdr_cnt_q;
  logic [CW-1:0] pay_cnt_q;
  logic [7:0]    gap_cnt_q;
  logic [15:0]   seq_q;
  logic [7:0]    dout_q;
  logic          dout_valid_q;

  assign full  = (fill_q == (AW+1)'(FIFO_DEPTH));
  assign rd_en = (state_q == S_PAYLOAD);
  assign wr_en = din_valid && (!full || rd_en);

  always_comb begin
    fill_d = fill_q;
    if (wr_en && !rd_en)
      fill_d = fill_q + 1'b1;
    else if (!wr_en && rd_en)
      fill_d = fill_q - 1'b1;
  end

  // Storage carries no reset; emptiness is defined purely by the pointers and fill.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      fill_q <= fill_d;
      if (wr_en)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      if (din_valid && !wr_en)
        overflow_q <= 1'b1;
    end
  end

  // The FIFO head is read asynchronously and registered straight into dout, so the
  // first payload byte lands in the cycle right after seq[7:0] with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      hdr_cnt_q    <= '0;
      pay_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      seq_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          dout_q       <= '0;
          dout_valid_q <= 1'b0;
          if (fill_q >= (AW+1)'(PAYLOAD_BYTES) && !tx_busy) begin
            state_q      <= S_HDR;
            hdr_cnt_q    <= 2'd1;
            dout_q       <= MAGIC[15:8];
            dout_valid_q <= 1'b1;
          end
        end
        S_HDR: begin
          dout_valid_q <= 1'b1;
          hdr_cnt_q    <= hdr_cnt_q + 2'd1;
          case (hdr_cnt_q)
            2'd1:    dout_q <= MAGIC[7:0];
            2'd2:    dout_q <= seq_q[15:8];
            default: begin
              dout_q    <= seq_q[7:0];
              state_q   <= S_PAYLOAD;
              pay_cnt_q <= '0;
            end
          endcase
        end
        S_PAYLOAD: begin
          dout_q       <= mem_q[rd_ptr_q];
          dout_valid_q <= 1'b1;
          pay_cnt_q    <= pay_cnt_q + 1'b1;
          if (pay_cnt_q == CW'(PAYLOAD_BYTES - 1)) begin
            state_q   <= S_GAP;
            gap_cnt_q <= '0;
            seq_q     <= seq_q + 16'd1;
          end
        end
        default: begin
          dout_q       <= '0;
          dout_valid_q <= 1'b0;
          gap_cnt_q    <= gap_cnt_q + 8'd1;
          if (gap_cnt_q == 8'(GAP_CYCLES - 1))
            state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overflow   = overflow_q;
  assign fill       = fill_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_adc_packetizer.sv
// Directed bench for adc_packetizer (16-byte payload, 64-byte FIFO, 4-cycle gap):
// captures every output packet byte and compares against hand-built expected streams.
module tb_adc_packetizer;

  localparam int          PB    = 16;
  localparam int          FD    = 64;
  localparam int          GC    = 4;
  localparam logic [15:0] MAGIC = 16'hADC0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       overflow;
  logic [6:0] fill;
  logic [1:0] state_dbg;

  adc_packetizer #(
    .PAYLOAD_BYTES(PB),
    .FIFO_DEPTH   (FD),
    .GAP_CYCLES   (GC),
    .MAGIC        (MAGIC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .tx_busy   (tx_busy),
    .dout      (dout),
    .dout_valid(dout_valid),
    .overflow  (overflow),
    .fill      (fill),
    .state_dbg (state_dbg)
  );

  // Clock / cycle counter
  always #4 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] out_q[$];
  int         run_q[$];
  int         gap_q[$];
  int         cur_run  = 0;
  int         idle_run = 0;
  bit         seen_run = 1'b0;
  int         idle_bad = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      cur_run  = 0;
      idle_run = 0;
      seen_run = 1'b0;
    end else if (dout_valid) begin
      if (cur_run == 0 && seen_run) gap_q.push_back(idle_run);
      out_q.push_back(dout);
      cur_run++;
      idle_run = 0;
    end else begin
      if (cur_run > 0) begin
        run_q.push_back(cur_run);
        seen_run = 1'b1;
      end
      cur_run = 0;
      idle_run++;
      if (dout !== 8'h00) idle_bad++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_sb();
    exp_q.delete();
    out_q.delete();
    run_q.delete();
    gap_q.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    din_valid = 1'b0;
    tx_busy   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_sb();
  endtask

  // Drives n consecutive bytes base, base+1, ... one per cycle.
  task automatic send_bytes(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din       = base + 8'(i);
      din_valid = 1'b1;
    end
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic push_pkt(input logic [15:0] seq, input logic [7:0] base);
    exp_q.push_back(MAGIC[15:8]);
    exp_q.push_back(MAGIC[7:0]);
    exp_q.push_back(seq[15:8]);
    exp_q.push_back(seq[7:0]);
    for (int i = 0; i < PB; i++) exp_q.push_back(base + 8'(i));
  endtask

  task automatic check_stream(input string tag);
    int n;
    check_eq({tag, "_len"}, out_q.size(), exp_q.size());
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check_eq($sformatf("%s_b%0d", tag, i), out_q[i], exp_q[i]);
  endtask

  initial begin
    int lat;
    bit hit;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_dout", dout, 8'h00);
    check_eq("rst_valid", dout_valid, 1'b0);
    check_eq("rst_ovf", overflow, 1'b0);
    check_eq("rst_fill", fill, 7'd0);
    check_eq("rst_state", state_dbg, 2'd0);

    // Single packet
    apply_reset();
    send_bytes(8'h00, 16);
    repeat (40) @(negedge clk);
    push_pkt(16'h0000, 8'h00);
    check_stream("single");
    check_eq("single_runs", run_q.size(), 1);
    if (run_q.size() > 0) check_eq("single_runlen", run_q[0], 20);
    check_eq("single_fill", fill, 7'd0);

    // Three back-to-back packets from a continuous stream
    apply_reset();
    send_bytes(8'h40, 48);
    repeat (60) @(negedge clk);
    push_pkt(16'h0000, 8'h40);
    push_pkt(16'h0001, 8'h50);
    push_pkt(16'h0002, 8'h60);
    check_stream("stream3");
    check_eq("stream3_gaps", gap_q.size(), 2);
    foreach (gap_q[i]) check_eq($sformatf("stream3_gap%0d", i), gap_q[i], GC);
    foreach (run_q[i]) check_eq($sformatf("stream3_run%0d", i), run_q[i], 20);

    // Overflow while the transmitter is busy
    apply_reset();
    tx_busy = 1'b1;
    send_bytes(8'h01, 70);
    @(negedge clk);
    #1;
    check_eq("ovf_fill", fill, 7'd64);
    check_eq("ovf_flag", overflow, 1'b1);
    check_eq("ovf_noout", out_q.size(), 0);
    tx_busy = 1'b0;
    repeat (120) @(negedge clk);
    push_pkt(16'h0000, 8'h01);
    push_pkt(16'h0001, 8'h11);
    push_pkt(16'h0002, 8'h21);
    push_pkt(16'h0003, 8'h31);
    check_stream("ovf");
    check_eq("ovf_sticky", overflow, 1'b1);
    check_eq("ovf_drained", fill, 7'd0);

    // Partial buffer never starts a packet; the 16th byte does
    apply_reset();
    send_bytes(8'h00, 15);
    repeat (100) @(negedge clk);
    check_eq("partial_noout", out_q.size(), 0);
    check_eq("partial_fill", fill, 7'd15);
    @(negedge clk);
    din       = 8'h0F;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    lat = cyc;
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge clk);
      #1;
      if (out_q.size() > 0) begin
        hit = 1'b1;
        lat = cyc - lat;
      end
    end
    check_eq("partial_started", hit, 1'b1);
    if (hit) check_eq("partial_latency", lat, 1);
    repeat (40) @(negedge clk);
    push_pkt(16'h0000, 8'h00);
    check_stream("partial");

    // Sequence number wrap
    apply_reset();
    @(negedge clk);
    force dut.seq_q = 16'hFFFF;
    @(negedge clk);
    release dut.seq_q;
    send_bytes(8'h00, 32);
    repeat (60) @(negedge clk);
    push_pkt(16'hFFFF, 8'h00);
    push_pkt(16'h0000, 8'h10);
    check_stream("wrap");

    // Reset in the middle of a payload
    apply_reset();
    send_bytes(8'hA0, 16);
    hit = 1'b0;
    for (int k = 0; k < 60 && !hit; k++) begin
      @(negedge clk);
      #1;
      if (out_q.size() >= 9) hit = 1'b1;
    end
    check_eq("midrst_reached", hit, 1'b1);
    check_eq("midrst_byte5", dout, 8'hA4);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", dout_valid, 1'b0);
    check_eq("midrst_dout", dout, 8'h00);
    check_eq("midrst_fill", fill, 7'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_sb();
    send_bytes(8'hB0, 16);
    repeat (40) @(negedge clk);
    push_pkt(16'h0000, 8'hB0);
    check_stream("midrst");

    check_eq("idle_dout_zero", idle_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_packetizer.md
ADC_PACKETIZER -- requirements
Module: adc_packetizer

Interface
REQ-001 The block SHALL have parameter PAYLOAD_BYTES, default 1024, payload bytes per packet (power of two, 16..2048).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4096, byte FIFO depth (power of two, >= 2*PAYLOAD_BYTES).
REQ-003 The block SHALL have parameter GAP_CYCLES, default 64, minimum idle clocks between packets (1..255).
REQ-004 The block SHALL have parameter MAGIC, default 16'hADC0, header marker.
REQ-005 The block SHALL have port clk, input, 1, single clock (clk_125m domain).
REQ-006 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port din, input, 8, byte from the ADC capture buffer.
REQ-008 The block SHALL have port din_valid, input, 1, din qualifier; there is no backpressure toward the source.
REQ-009 The block SHALL have port tx_busy, input, 1, UDP transmitter busy flag.
REQ-010 The block SHALL have port dout, output, 8, packet byte to the UDP transmitter.
REQ-011 The block SHALL have port dout_valid, output, 1, dout qualifier; contiguous for a whole packet.
REQ-012 The block SHALL have port overflow, output, 1, sticky flag: byte dropped.
REQ-013 The block SHALL have port fill, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Function
REQ-014 Each cycle with din_valid=1 and fill<FIFO_DEPTH SHALL write din to the FIFO tail.
REQ-015 A write when fill==FIFO_DEPTH SHALL drop the byte, leave the FIFO unchanged and set overflow=1 until reset.
REQ-016 A write and a read in the same cycle SHALL leave fill unchanged.
REQ-017 A write and a read in the same cycle with fill==FIFO_DEPTH SHALL be accepted.
REQ-018 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 The FSM SHALL have the states IDLE, HDR, PAYLOAD and GAP.
REQ-020 IDLE -> HDR SHALL occur when fill >= PAYLOAD_BYTES and tx_busy==0, both sampled in the same cycle.
REQ-021 HDR SHALL last 4 cycles emitting MAGIC[15:8], MAGIC[7:0], seq[15:8], seq[7:0], each with dout_valid=1.
REQ-022 The first header byte SHALL appear on the registered outputs in the cycle after the IDLE->HDR decision.
REQ-023 PAYLOAD SHALL emit exactly PAYLOAD_BYTES FIFO bytes in FIFO order, one per cycle, with dout_valid=1 and no bubbles.
REQ-024 The FIFO read SHALL be pre-issued so that the first payload byte directly follows seq[7:0].
REQ-025 Each packet SHALL consist of 4+PAYLOAD_BYTES consecutive valid cycles; tx_busy SHALL be ignored once HDR has been entered.
REQ-026 After the last payload byte the FSM SHALL enter GAP with dout_valid=0 and dout=0 for exactly GAP_CYCLES cycles, then go to IDLE.
REQ-027 seq SHALL be 16 bits, start at 0, increment by 1 on PAYLOAD->GAP, and wrap from 16'hFFFF to 16'h0000.
REQ-028 Outside HDR and PAYLOAD, dout_valid SHALL be 0 and dout SHALL be 8'h00.
REQ-029 A packet SHALL never start with fewer than PAYLOAD_BYTES bytes buffered; partial packets SHALL never be sent.
REQ-030 fill SHALL be registered and reflect writes and reads of the previous cycle.

Reset
REQ-031 rst_n=0 SHALL immediately force dout=0, dout_valid=0, overflow=0, fill=0, seq=0, FSM=IDLE, and empty the FIFO pointers.
REQ-032 Reset asserted mid-packet SHALL abort the packet with no further valid bytes; buffered data SHALL be discarded.
REQ-033 Reset deassertion SHALL be assumed synchronised externally; the first write SHALL be accepted on the first clk edge with rst_n=1.

Verification (PAYLOAD_BYTES=16, FIFO_DEPTH=64, GAP_CYCLES=4)
REQ-034 Stream 16 bytes 0x00..0x0F, tx_busy=0 -> 20 contiguous valid bytes AD C0 00 00 00..0F, then exactly 4 idle cycles; fill returns to 0.
REQ-035 Stream 48 bytes continuously -> three packets with seq 0x0000, 0x0001, 0x0002, GAP=4 between packets, and payload order preserved.
REQ-036 Hold tx_busy=1 while writing 70 bytes -> fill saturates at 64, overflow=1, bytes 65..70 lost; release tx_busy -> packets carry bytes 1..64 in order.
REQ-037 Write 15 bytes, wait 100 cycles -> dout_valid stays 0; the 16th byte triggers a packet starting 1 cycle after the IDLE->HDR decision.
REQ-038 Preload seq to 0xFFFF (force or 65535 packets) -> next header carries FF FF, the following header carries 00 00.
REQ-039 Assert rst_n=0 at payload byte 5 -> dout_valid=0 in the same cycle, fill=0, and the next packet after 16 new bytes carries seq 0x0000.
